iomem_gpio: RTL and testbench

- Parametrised GPIO peripheral on the picosoc iomem bus. Successor to the single 8-bit LED register.
- Adds per-pin output enable and a synchronised input read-back.
- Adds edge-triggered interrupts with mask and write-1-to-clear status; `irq` is wired to one of `irq_5`..`irq_7`.
- Occupies one 16 MB iomem window selected by `addr[31:24]`.

---
 rtl/iomem_gpio.sv | 159 +++++++++++++++
 tb/tb_iomem_gpio.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_gpio.sv
// iomem_gpio: parametrised GPIO peripheral on the picosoc iomem bus.
// Registers: OUT, OE, IN (synchronised pins), IRQ_EN, EDGE, STATUS (W1C).
// Optional macro IOMEM_GPIO_SET_CLR_EN adds write-only OUT_SET (0x18) and
// OUT_CLR (0x1C); without it those offsets behave as unmapped.
module iomem_gpio #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [7:0]  BASE        = 8'h03,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [2:0] SEL_OUT    = 3'd0;
  localparam logic [2:0] SEL_OE     = 3'd1;
  localparam logic [2:0] SEL_IN     = 3'd2;
  localparam logic [2:0] SEL_IRQ_EN = 3'd3;
  localparam logic [2:0] SEL_EDGE   = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;
`ifdef IOMEM_GPIO_SET_CLR_EN
  localparam logic [2:0] SEL_SET    = 3'd6;
  localparam logic [2:0] SEL_CLR    = 3'd7;
`endif

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic             hit, we;
  logic [2:0]       sel;
  logic [WIDTH-1:0] wmask, wval, sync_v, ev, w1c, rd_val;
  logic             unused_bits;

  // Address bits below the register select and the window offset are don't-care.
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata};

  // Bus decode and per-bit byte-strobe mask.
  always_comb begin
    hit    = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE);
    we     = hit && (iomem_wstrb != 4'h0);
    sel    = iomem_addr[4:2];
    wmask  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      wmask[i] = iomem_wstrb[i / 8];
    end
    wval   = iomem_wdata[WIDTH-1:0] & wmask;
    sync_v = sync_q[SYNC_STAGES-1];
  end

  // Input synchroniser chain and edge detection.
  always_comb begin
    sync_d[0] = gpio_i;
    for (int s = 1; s < int'(SYNC_STAGES); s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_v;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ev[i] = edge_q[i] ? (!sync_v[i] && prev_q[i]) : (sync_v[i] && !prev_q[i]);
    end
  end

  // Read mux: returns register contents prior to any write in this access.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_OUT:    rd_val = out_q;
      SEL_OE:     rd_val = oe_q;
      SEL_IN:     rd_val = sync_v;
      SEL_IRQ_EN: rd_val = irq_en_q;
      SEL_EDGE:   rd_val = edge_q;
      SEL_STATUS: rd_val = status_q;
      default:    rd_val = '0;
    endcase
  end

  // Next-state for handshake, registers, status and interrupt.
  always_comb begin
    ready_d  = hit;
    rdata_d  = hit ? 32'(rd_val) : rdata_q;
    out_d    = out_q;
    oe_d     = oe_q;
    irq_en_d = irq_en_q;
    edge_d   = edge_q;
    w1c      = '0;
    if (we) begin
      case (sel)
        SEL_OUT:    out_d    = (out_q    & ~wmask) | wval;
        SEL_OE:     oe_d     = (oe_q     & ~wmask) | wval;
        SEL_IRQ_EN: irq_en_d = (irq_en_q & ~wmask) | wval;
        SEL_EDGE:   edge_d   = (edge_q   & ~wmask) | wval;
        SEL_STATUS: w1c      = wval;
`ifdef IOMEM_GPIO_SET_CLR_EN
        SEL_SET:    out_d    = out_q | wval;
        SEL_CLR:    out_d    = out_q & ~wval;
`endif
        default:    ;
      endcase
    end
    // A new event outranks a clear landing in the same cycle.
    status_d = (status_q & ~w1c) | ev;
    irq_d    = |(status_q & irq_en_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      irq_en_q <= '0;
      edge_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      irq_en_q <= irq_en_d;
      edge_q   <= edge_d;
      status_q <= status_d;
      prev_q   <= prev_d;
      irq_q    <= irq_d;
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_o      = out_q;
  assign gpio_oe     = oe_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Scoreboard bench for iomem_gpio (WIDTH=8, BASE=8'h03, SYNC_STAGES=2).
module tb_iomem_gpio;

  localparam int unsigned W = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [W-1:0] gpio_i, gpio_o, gpio_oe;
  logic        irq;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic ack_prev = 1'b0;

  iomem_gpio #(.WIDTH(W), .BASE(8'h03), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on every ack and checks single-cycle acks.
  always @(negedge clk) begin
    exp_t e;
    if (ack_prev) begin
      n_checks++;
      if (iomem_ready) begin
        n_fail++;
        $display("FAIL ready_pulse: ready=1 on consecutive cycles, required 0");
      end
    end
    ack_prev = iomem_ready;
    if (iomem_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: ack with empty scoreboard");
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          n_checks++;
          if (iomem_rdata !== e.exp) begin
            n_fail++;
            $display("FAIL %s: rdata=%h required %h", e.name, iomem_rdata, e.exp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [4:0] off, input logic [3:0] strb, input logic [31:0] wd,
                     input logic chk, input logic [31:0] exp, input string name);
    exp_t e;
    int   cyc;
    @(negedge clk);
    e.chk = chk; e.exp = exp; e.name = name;
    sb.push_back(e);
    iomem_valid = 1'b1;
    iomem_addr  = {8'h03, 19'h0, off};
    iomem_wstrb = strb;
    iomem_wdata = wd;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!iomem_ready && cyc < 8);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (!iomem_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no ack within 8 cycles, required ack", name);
      void'(sb.pop_back());
    end
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string name);
    bus(off, 4'h0, 32'h0, 1'b1, exp, name);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] wd, input logic [3:0] strb);
    bus(off, strb, wd, 1'b0, 32'h0, "write");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_set, exp_clr;
`ifdef IOMEM_GPIO_SET_CLR_EN
    exp_set = 32'hFF; exp_clr = 32'h7E;
`else
    exp_set = 32'h0F; exp_clr = 32'h0F;
`endif
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    iomem_addr = 32'h0; iomem_wdata = 32'h0; gpio_i = '0;
    idle(3);
    check("rst_ready", 32'(iomem_ready), 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    resetn = 1'b1;
    idle(2);

    // All registers read zero after reset.
    for (int k = 0; k < 6; k++) rd(5'(k * 4), 32'h0, "rst_reg_read");

    // OUT write with full and partial strobes.
    wr(5'h00, 32'hA5A5_A5A5, 4'hF);
    check("out_full_wr", 32'(gpio_o), 32'hA5);
    rd(5'h00, 32'h0000_00A5, "out_read");
    wr(5'h00, 32'h5A5A_5A5A, 4'h2);
    check("out_strb_miss", 32'(gpio_o), 32'hA5);
    iomem_addr = 32'h0;

    // OE and synchronised input read-back latency.
    wr(5'h04, 32'h0F, 4'hF);
    check("oe_wr", 32'(gpio_oe), 32'h0F);
    @(negedge clk);
    gpio_i = 8'h3C;
    rd(5'h08, 32'h0, "in_too_early");
    rd(5'h08, 32'h3C, "in_sync");
    wr(5'h08, 32'hFF, 4'hF);
    rd(5'h08, 32'h3C, "in_ro");
    rd(5'h14, 32'h3C, "status_rise_3c");
    wr(5'h14, 32'hFF, 4'hF);
    rd(5'h14, 32'h0, "status_w1c_all");
    gpio_i = 8'h00;
    idle(5);
    rd(5'h14, 32'h0, "status_fall_ignored");

    // Rising edge interrupt, W1C, falling edge ignored.
    wr(5'h0C, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    idle(5);
    rd(5'h14, 32'h01, "status_rise0");
    check("irq_set", 32'(irq), 32'h1);
    wr(5'h14, 32'h01, 4'hF);
    rd(5'h14, 32'h0, "status_cleared");
    idle(2);
    check("irq_clear", 32'(irq), 32'h0);
    gpio_i[0] = 1'b0;
    idle(5);
    rd(5'h14, 32'h0, "status_fall0");

    // Falling-edge mode; changing EDGE creates no event.
    wr(5'h10, 32'h01, 4'hF);
    idle(3);
    rd(5'h14, 32'h0, "edge_change_no_ev");
    gpio_i[0] = 1'b1;
    idle(5);
    rd(5'h14, 32'h0, "edge_fall_mode_rise");
    gpio_i[0] = 1'b0;
    idle(5);
    rd(5'h14, 32'h01, "edge_fall_mode_fall");
    wr(5'h14, 32'h01, 4'hF);
    wr(5'h10, 32'h00, 4'hF);

    // Event on bit 1 coinciding with its W1C: the event wins.
    gpio_i[1] = 1'b1;
    idle(5);
    gpio_i[1] = 1'b0;
    idle(5);
    rd(5'h14, 32'h02, "status_bit1_pre");
    @(negedge clk);
    gpio_i[1] = 1'b1;
    @(negedge clk);
    wr(5'h14, 32'h02, 4'hF);
    rd(5'h14, 32'h02, "status_set_wins");
    check("irq_masked_bit1", 32'(irq), 32'h0);
    wr(5'h14, 32'h02, 4'hF);
    rd(5'h14, 32'h0, "status_bit1_clr");

    // OUT_SET / OUT_CLR (or unmapped without the feature).
    wr(5'h00, 32'h0F, 4'hF);
    wr(5'h18, 32'hF0, 4'hF);
    rd(5'h00, exp_set, "out_after_set");
    wr(5'h1C, 32'h81, 4'hF);
    rd(5'h00, exp_clr, "out_after_clr");
    check("gpio_o_after_clr", 32'(gpio_o), exp_clr);
    rd(5'h18, 32'h0, "set_reads_0");
    rd(5'h1C, 32'h0, "clr_reads_0");
    rd(5'h04, 32'h0F, "oe_untouched");

    // Reset asserted mid-access drops the ack and the write.
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000;
    iomem_wdata = 32'h33; iomem_wstrb = 4'hF;
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 32'(iomem_ready), 32'h0);
    check("midrst_gpio_o", 32'(gpio_o), 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    @(negedge clk);
    resetn = 1'b1;
    rd(5'h00, 32'h0, "out_after_midrst");
    idle(3);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
